ps2_key_tracker: RTL and testbench

//  Consumes the byte stream from ps2_rx (rx_done_tick + scan_code) and tracks
//  the make/break state of the six game keys. Decodes F0 break and E0

---
 rtl/ps2_key_tracker.sv | 194 +++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code tracker for six game keys: decodes F0/E0 prefixes into held levels and press/release pulses.
// Optional build macro PS2_ARROW_KEYS_EN aliases E0-prefixed arrow keys onto key indices 0..3.
module ps2_key_tracker #(
    parameter logic [7:0]  CODE_LEFT      = 8'h1C,
    parameter logic [7:0]  CODE_RIGHT     = 8'h23,
    parameter logic [7:0]  CODE_UP        = 8'h1D,
    parameter logic [7:0]  CODE_DOWN      = 8'h1B,
    parameter logic [7:0]  CODE_RESET     = 8'h2D,
    parameter logic [7:0]  CODE_ENTER     = 8'h29,
    parameter int unsigned PREFIX_TIMEOUT = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] scan_code,
    output logic [5:0] key_held,
    output logic [5:0] key_press,
    output logic [5:0] key_release,
    output logic       any_held
);

    localparam int unsigned CW = (PREFIX_TIMEOUT > 32'd1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PREFIX_TIMEOUT - 32'd1);
    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam logic [7:0] BYTE_EXT = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_s;
    logic          is_make_s, is_brk_s, is_ext_s;
    logic [5:0]    held_main_q, held_main_d;
    logic [3:0]    held_ext_d;
    logic [5:0]    key_held_d;
    logic [5:0]    key_held_q, key_press_q, key_release_q;
    logic          any_held_q;

    function automatic logic [5:0] main_match(input logic [7:0] code);
        main_match = {(code == CODE_ENTER), (code == CODE_RESET), (code == CODE_DOWN),
                      (code == CODE_UP), (code == CODE_RIGHT), (code == CODE_LEFT)};
    endfunction

    assign timeout_s = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a byte arriving in the expiry cycle beats the timeout
    always_comb begin
        state_d = state_q;
        if (rx_done_tick) begin
            case (state_q)
                ST_IDLE, ST_BRK: begin
                    if (scan_code == BYTE_BRK)      state_d = ST_BRK;
                    else if (scan_code == BYTE_EXT) state_d = ST_EXT;
                    else                            state_d = ST_IDLE;
                end
                ST_EXT, ST_EXT_BRK: begin
                    if (scan_code == BYTE_BRK)      state_d = ST_EXT_BRK;
                    else if (scan_code == BYTE_EXT) state_d = ST_EXT;
                    else                            state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs: classify a non-prefix byte as make/break, main/extended
    always_comb begin
        is_make_s = 1'b0;
        is_brk_s  = 1'b0;
        is_ext_s  = 1'b0;
        if (rx_done_tick && (scan_code != BYTE_BRK) && (scan_code != BYTE_EXT)) begin
            case (state_q)
                ST_IDLE:    is_make_s = 1'b1;
                ST_BRK:     is_brk_s  = 1'b1;
                ST_EXT:     begin is_make_s = 1'b1; is_ext_s = 1'b1; end
                ST_EXT_BRK: begin is_brk_s  = 1'b1; is_ext_s = 1'b1; end
                default:    is_make_s = 1'b0;
            endcase
        end else begin
            is_make_s = 1'b0;
        end
    end

    // prefix timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // counter runs only while a prefix is pending and no byte arrives
    always_comb begin
        if (rx_done_tick || (state_q == ST_IDLE) || timeout_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // main-key held state next value
    always_comb begin
        held_main_d = held_main_q;
        if (is_make_s && !is_ext_s) begin
            held_main_d = held_main_q | main_match(scan_code);
        end else if (is_brk_s && !is_ext_s) begin
            held_main_d = held_main_q & ~main_match(scan_code);
        end else begin
            held_main_d = held_main_q;
        end
    end

    // main-key held register
    always_ff @(posedge clk) begin
        if (reset) begin
            held_main_q <= '0;
        end else begin
            held_main_q <= held_main_d;
        end
    end

`ifdef PS2_ARROW_KEYS_EN
    logic [3:0] held_ext_q;

    function automatic logic [3:0] ext_match(input logic [7:0] code);
        ext_match = {(code == 8'h72), (code == 8'h75), (code == 8'h74), (code == 8'h6B)};
    endfunction

    // arrow-key held state next value
    always_comb begin
        held_ext_d = held_ext_q;
        if (is_make_s && is_ext_s) begin
            held_ext_d = held_ext_q | ext_match(scan_code);
        end else if (is_brk_s && is_ext_s) begin
            held_ext_d = held_ext_q & ~ext_match(scan_code);
        end else begin
            held_ext_d = held_ext_q;
        end
    end

    // arrow-key held register
    always_ff @(posedge clk) begin
        if (reset) begin
            held_ext_q <= '0;
        end else begin
            held_ext_q <= held_ext_d;
        end
    end
`else
    assign held_ext_d = 4'b0000;
`endif

    assign key_held_d = held_main_d | {2'b00, held_ext_d};

    // registered outputs; pulses compare new level against the previous one
    always_ff @(posedge clk) begin
        if (reset) begin
            key_held_q    <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            any_held_q    <= 1'b0;
        end else begin
            key_held_q    <= key_held_d;
            key_press_q   <= key_held_d & ~key_held_q;
            key_release_q <= ~key_held_d & key_held_q;
            any_held_q    <= |key_held_d;
        end
    end

    assign key_held    = key_held_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign any_held    = any_held_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed self-checking bench for ps2_key_tracker with a shortened prefix timeout.
module tb_ps2_key_tracker;

    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic [5:0] key_held, key_press, key_release;
    logic       any_held;

    int n_assert = 0;
    int n_fail   = 0;

    ps2_key_tracker #(.PREFIX_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .scan_code    (scan_code),
        .key_held     (key_held),
        .key_press    (key_press),
        .key_release  (key_release),
        .any_held     (any_held)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // returns on the negedge right after the capturing posedge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        scan_code    = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
        scan_code    = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // 1: reset and idle
        idle(3);
        reset = 1'b0;
        idle(100);
        check_eq("rst_held", {2'b00, key_held}, 8'h00);
        check_eq("rst_press", {2'b00, key_press}, 8'h00);
        check_eq("rst_release", {2'b00, key_release}, 8'h00);
        check_eq("rst_any", {7'd0, any_held}, 8'h00);

        // 2: make + typematic repeats
        send_byte(8'h1C);
        check_eq("make_held", {2'b00, key_held}, 8'b0000_0001);
        check_eq("make_press", {2'b00, key_press}, 8'b0000_0001);
        check_eq("make_any", {7'd0, any_held}, 8'h01);
        idle(1);
        check_eq("press_one_cycle", {2'b00, key_press}, 8'h00);
        send_byte(8'h1C);
        check_eq("rep1_press", {2'b00, key_press}, 8'h00);
        send_byte(8'h1C);
        check_eq("rep2_press", {2'b00, key_press}, 8'h00);
        check_eq("rep2_held", {2'b00, key_held}, 8'b0000_0001);

        // 3: break
        send_byte(8'hF0);
        check_eq("f0_held", {2'b00, key_held}, 8'b0000_0001);
        check_eq("f0_release", {2'b00, key_release}, 8'h00);
        send_byte(8'h1C);
        check_eq("brk_held", {2'b00, key_held}, 8'h00);
        check_eq("brk_release", {2'b00, key_release}, 8'b0000_0001);
        check_eq("brk_any", {7'd0, any_held}, 8'h00);
        idle(1);
        check_eq("release_one_cycle", {2'b00, key_release}, 8'h00);

        // 4a: F0 alone, then a byte landing exactly in the expiry cycle is still a break
        send_byte(8'hF0);
        check_eq("f0_alone_held", {2'b00, key_held}, 8'h00);
        idle(TMO - 2);
        send_byte(8'h23);
        check_eq("expiry_cycle_is_break", {2'b00, key_held}, 8'h00);
        // 4b: one cycle later the prefix has expired and the byte is a make
        send_byte(8'hF0);
        idle(TMO - 1);
        send_byte(8'h23);
        check_eq("timeout_make_held", {2'b00, key_held}, 8'b0000_0010);
        check_eq("timeout_make_press", {2'b00, key_press}, 8'b0000_0010);

        // 5: main and extended sources of key 0
        send_byte(8'h1C);
        check_eq("a_press", {2'b00, key_press}, 8'b0000_0001);
        send_byte(8'hE0);
        send_byte(8'h6B);
        check_eq("ext_make_held", {2'b00, key_held}, 8'b0000_0011);
        check_eq("ext_make_press", {2'b00, key_press}, 8'h00);
        send_byte(8'hF0);
        send_byte(8'h1C);
`ifdef PS2_ARROW_KEYS_EN
        check_eq("main_brk_held", {2'b00, key_held}, 8'b0000_0011);
        check_eq("main_brk_release", {2'b00, key_release}, 8'h00);
`else
        check_eq("main_brk_held", {2'b00, key_held}, 8'b0000_0010);
        check_eq("main_brk_release", {2'b00, key_release}, 8'b0000_0001);
`endif
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        check_eq("ext_brk_held", {2'b00, key_held}, 8'b0000_0010);
`ifdef PS2_ARROW_KEYS_EN
        check_eq("ext_brk_release", {2'b00, key_release}, 8'b0000_0001);
`else
        check_eq("ext_brk_release", {2'b00, key_release}, 8'h00);
`endif
        send_byte(8'hF0);
        send_byte(8'h23);
        check_eq("d_release", {2'b00, key_release}, 8'b0000_0010);
        check_eq("d_any", {7'd0, any_held}, 8'h00);

        // 6: reset concurrent with a break prefix tick
        send_byte(8'h29);
        send_byte(8'h2D);
        check_eq("two_held", {2'b00, key_held}, 8'b0011_0000);
        @(negedge clk);
        rx_done_tick = 1'b1;
        scan_code    = 8'hF0;
        reset        = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        scan_code    = 8'h00;
        reset        = 1'b0;
        check_eq("srst_held", {2'b00, key_held}, 8'h00);
        check_eq("srst_release", {2'b00, key_release}, 8'h00);
        check_eq("srst_any", {7'd0, any_held}, 8'h00);
        send_byte(8'h29);
        check_eq("post_rst_held", {2'b00, key_held}, 8'b0010_0000);
        check_eq("post_rst_press", {2'b00, key_press}, 8'b0010_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
